// File: rtl/axi_deserializer_multilane.sv
// axi_deserializer_multilane
// Packs narrow AXI-Stream beats (IN_WIDTH bits) into wide words (OUT_WIDTH bits).
// The first beat of a word lands in the most significant slot. Completed words
// go into a 2-entry output buffer, so a word can be held under backpressure
// while the next one is collected.
//
// Parameters:
//   IN_WIDTH  - bits per input beat
//   OUT_WIDTH - bits per output word. It must be a multiple of IN_WIDTH, and
//               OUT_WIDTH/IN_WIDTH (RATIO) must be at least 2.
//
// Ports:
//   clk, rst       - rising-edge clock; synchronous active-high reset
//   clear          - drops the partial word being collected; buffered words stay
//   reverse_output - bit-reverses the presented o_tdata word
//   i_t*           - AXI-Stream slave (tdata/tlast/tvalid in, tready out)
//   o_t*           - AXI-Stream master (tdata/tlast/tvalid out, tready in)
//   o_nbeats       - number of valid input beats in the presented word
//
// Optional build macro: AXI_DESERIALIZER_MULTILANE_FLUSH_EN
//   Defined: an accepted i_tlast pushes the partial word at once. Unfilled
//            slots are zero and o_nbeats gives the number of beats taken.
//   Default: i_tlast is latched and attached to the next full word.
module axi_deserializer_multilane #(
  parameter int unsigned IN_WIDTH  = 1,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 reverse_output,
  input  logic [IN_WIDTH-1:0]                  i_tdata,
  input  logic                                 i_tlast,
  input  logic                                 i_tvalid,
  output logic                                 i_tready,
  output logic [OUT_WIDTH-1:0]                 o_tdata,
  output logic                                 o_tlast,
  output logic                                 o_tvalid,
  input  logic                                 o_tready,
  output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]  o_nbeats
);

  localparam int unsigned RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned SLOT_W = $clog2(RATIO);
  localparam int unsigned NB_W   = SLOT_W + 1;
  localparam logic [SLOT_W-1:0] SLOT_TOP = SLOT_W'(RATIO - 1);

  // Accumulator state
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 tlast_pend_q, tlast_pend_d;

  // Two-entry output buffer
  logic [OUT_WIDTH-1:0] buf_data_q [2];
  logic [OUT_WIDTH-1:0] buf_data_d [2];
  logic                 buf_last_q [2];
  logic                 buf_last_d [2];
  logic [NB_W-1:0]      buf_nb_q   [2];
  logic [NB_W-1:0]      buf_nb_d   [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;

  // Combinational helpers
  logic                 beat_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 flush_c;
  logic [OUT_WIDTH-1:0] acc_merged_c;
  logic [OUT_WIDTH-1:0] head_c;
  logic [OUT_WIDTH-1:0] rev_c;

  // Handshake flags come only from the buffer occupancy. i_tready has no
  // path from i_tvalid. It is also held low while rst is high.
  assign i_tready = ~rst & (count_q < 2'd2);
  assign o_tvalid = (count_q != 2'd0);
  assign o_tlast  = buf_last_q[rd_ptr_q];
  assign o_nbeats = buf_nb_q[rd_ptr_q];

  // Bit reversal is applied at the buffer head only.
  // The stored words are never reversed.
  always_comb begin
    head_c = buf_data_q[rd_ptr_q];
    rev_c  = '0;
    for (int i = 0; i < int'(OUT_WIDTH); i++) begin
      rev_c[i] = head_c[int'(OUT_WIDTH) - 1 - i];
    end
    o_tdata = reverse_output ? rev_c : head_c;
  end

  // Next-state logic for the accumulator and the output buffer
  always_comb begin
    slot_d       = slot_q;
    acc_d        = acc_q;
    tlast_pend_d = tlast_pend_q;
    buf_data_d   = buf_data_q;
    buf_last_d   = buf_last_q;
    buf_nb_d     = buf_nb_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

`ifdef AXI_DESERIALIZER_MULTILANE_FLUSH_EN
    flush_c = i_tlast;
`else
    flush_c = 1'b0;
`endif

    // clear wins over a beat arriving in the same cycle
    beat_c       = i_tvalid & i_tready & ~clear;
    pop_c        = o_tvalid & o_tready;
    acc_merged_c = acc_q | (OUT_WIDTH'(i_tdata) << (32'(slot_q) * IN_WIDTH));
    push_c       = beat_c & ((slot_q == '0) | flush_c);

    if (clear) begin
      slot_d       = SLOT_TOP;
      acc_d        = '0;
      tlast_pend_d = 1'b0;
    end else if (push_c) begin
      buf_data_d[wr_ptr_q] = acc_merged_c;
      buf_last_d[wr_ptr_q] = tlast_pend_q | i_tlast;
      buf_nb_d[wr_ptr_q]   = NB_W'(RATIO) - NB_W'(slot_q);
      wr_ptr_d             = ~wr_ptr_q;
      slot_d               = SLOT_TOP;
      acc_d                = '0;
      tlast_pend_d         = 1'b0;
    end else if (beat_c) begin
      acc_d        = acc_merged_c;
      slot_d       = slot_q - SLOT_W'(1);
      tlast_pend_d = tlast_pend_q | i_tlast;
    end

    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // A push is only accepted below occupancy 2, so the count cannot overflow
    count_d = count_q + 2'(push_c) - 2'(pop_c);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= SLOT_TOP;
      acc_q        <= '0;
      tlast_pend_q <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
        buf_nb_q[i]   <= '0;
      end
    end else begin
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      tlast_pend_q <= tlast_pend_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      buf_data_q   <= buf_data_d;
      buf_last_q   <= buf_last_d;
      buf_nb_q     <= buf_nb_d;
    end
  end

endmodule
